ac_sweep_stimulus: RTL and testbench
====================================

Name: ac_sweep_stimulus

Overview:
- Stimulus side of the AC/group-delay measurement chain. It steps an NCO frequency word across N sweep points.
- At each point it drives a phase-coherent tone, waits a settle interval, then dwells while the downstream wave/phase receiver integrates.
- At the end of the dwell it hands that point's index and frequency word to the receiver, and does not advance until the receiver accepts it.
- It sits between the sweep-control registers and the sine-LUT/DAC path feeding port 1. Port 2's source is held at zero amplitude.

Parameters:
- FREQ_W, 32, width of the frequency tuning word and the phase accumulator.
- PHASE_W, 12, width of the truncated phase output to the sine LUT. Must satisfy PHASE_W <= FREQ_W.
- NPTS_W, 10, width of the point count and point index.
- CNT_W, 16, width of the settle and dwell counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a sweep. Honoured only in IDLE or DONE.
- abort  in  1  synchronous sweep abort. Effective in any state.
- f_start  in  FREQ_W  tuning word for point 0.
- f_step  in  FREQ_W  tuning-word increment per point.
- n_points  in  NPTS_W  number of sweep points.
- settle_cycles  in  CNT_W  cycles between tone start and dwell start.
- dwell_cycles  in  CNT_W  dwell length in cycles. 0 is treated as 1.
- tone_en  out  1  tone active; the LUT output is gated by this.
- phase  out  PHASE_W  accumulator MSBs, to the sine LUT.
- dwell  out  1  receiver integration window.
- pt_valid  out  1  point result handoff is valid.
- pt_ready  in  1  receiver accepts the point.
- pt_idx  out  NPTS_W  index of the current point.
- pt_freq  out  FREQ_W  tuning word of the current point.
- busy  out  1  high in any state other than IDLE or DONE.
- done  out  1  high in DONE until the next start.

Behaviour:
- Reset: every output is 0. Accumulator, counters and index are 0. State is IDLE.
- start and control inputs:
  - On a start accepted in IDLE or DONE, f_start, f_step, n_points, settle_cycles and dwell_cycles are latched. Later changes to these inputs are ignored until the next start.
  - start is ignored while busy.
- State machine, with transitions registered on clk:
  - IDLE/DONE --start--> if latched n_points == 0: DONE on the next cycle with done=1, and no point is emitted. Otherwise go to SETTLE with pt_idx=0, pt_freq=f_start, accumulator cleared, tone_en=1.
  - SETTLE: the counter counts settle_cycles cycles, then the state moves to DWELL. If settle_cycles == 0, DWELL is entered on the next cycle.
  - DWELL: dwell=1 for exactly max(dwell_cycles,1) cycles, then the state moves to HANDOFF.
  - HANDOFF: pt_valid=1; tone_en stays 1; dwell=0. pt_idx and pt_freq are held stable while pt_valid=1 and pt_ready=0.
    - On pt_valid & pt_ready, if pt_idx == n_points-1: go to DONE.
    - Otherwise: pt_idx+1, pt_freq+f_step (mod 2^FREQ_W, wrap silently), accumulator cleared, state SETTLE.
    - The transfer costs no extra cycle.
  - DONE: tone_en=0, done=1. A new start restarts the sweep directly.
- Phase accumulator:
  - Steps acc <= acc + pt_freq every cycle while tone_en=1. It is 0 on the first tone cycle of each point, which gives phase-coherent zero-phase starts.
  - phase = acc[FREQ_W-1 -: PHASE_W], registered, with 1 cycle latency from acc.
  - When tone_en=0, acc holds at 0.
- abort: from any state, go to IDLE on the next edge. tone_en, dwell and pt_valid drop that edge and done=0. abort takes priority over a simultaneous start or pt_ready; the point is not counted as transferred.
- Reset mid-sweep: asynchronous clear to the reset values. No handoff is pending afterwards.
- pt_valid never deasserts without a handshake except on abort or reset.

Decomposition:
- Shared package ac_sweep_pkg:
  - state enum {IDLE, SETTLE, DWELL, HANDOFF, DONE};
  - default width constants FREQ_W/PHASE_W/NPTS_W/CNT_W.
- One sub-module, nco_phase_acc (FREQ_W, PHASE_W), with ports clk, rst_n, clr, en, fword, phase.

Test Plan:
- Sweep with n_points=3, f_start=32'h1000_0000, f_step=32'h0800_0000, settle=4, dwell=8, pt_ready held 1 -> pt_valid pulses exactly 3 times, with pt_freq 1000_0000, 1800_0000, 2000_0000 and pt_idx 0,1,2. Each point spans 4+8+1=13 cycles. done=1 on the cycle after the third transfer.
- Phase stepping: f_start=32'h4000_0000, PHASE_W=12 -> phase sequence 000, 400, 800, C00, 000 over the first tone cycles (1-cycle latency). It restarts at 000 on each new point.
- Backpressure: pt_ready low for 5 cycles in HANDOFF -> pt_valid, pt_idx and pt_freq are stable for all 5 cycles and tone_en stays 1. The next point begins the cycle after pt_ready=1.
- Zero-point and zero-length intervals:
  - n_points=0 -> done one cycle after start, and pt_valid is never asserted.
  - settle=0, dwell=0 -> dwell high exactly 1 cycle per point.
- Frequency wrap: f_start=32'hF000_0000, f_step=32'h2000_0000, n_points=2 -> second pt_freq = 32'h1000_0000.
- Abort and reset:
  - abort asserted in HANDOFF together with pt_ready -> IDLE next edge; pt_valid, tone_en and done are 0.
  - rst_n low mid-DWELL -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ac_sweep_pkg.sv
// Shared types and default widths for the AC sweep stimulus generator.
package ac_sweep_pkg;

    localparam int DEF_FREQ_W  = 32;
    localparam int DEF_PHASE_W = 12;
    localparam int DEF_NPTS_W  = 10;
    localparam int DEF_CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        DWELL   = 3'd2,
        HANDOFF = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/nco_phase_acc.sv
// Phase accumulator for the sweep tone; the registered MSBs address the sine LUT.
module nco_phase_acc
    import ac_sweep_pkg::*;
#(
    parameter int FREQ_W  = DEF_FREQ_W,
    parameter int PHASE_W = DEF_PHASE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [FREQ_W-1:0]  fword,
    output logic [PHASE_W-1:0] phase
);

    logic [FREQ_W-1:0]  acc_p0;
    logic [PHASE_W-1:0] phase_p1;

    // Clearing the phase register together with the accumulator makes every
    // point start from zero phase, not from the tail of the previous tone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p0   <= '0;
            phase_p1 <= '0;
        end else if (clr) begin
            acc_p0   <= '0;
            phase_p1 <= '0;
        end else begin
            // stage p0 -> p1: truncate accumulator to LUT address
            phase_p1 <= acc_p0[FREQ_W-1 -: PHASE_W];
            if (en) begin
                acc_p0 <= acc_p0 + fword;
            end
        end
    end

    assign phase = phase_p1;

endmodule

// File: rtl/ac_sweep_stimulus.sv
// Steps an NCO across the sweep points: settle, dwell, then hand each point to the receiver.
module ac_sweep_stimulus
    import ac_sweep_pkg::*;
#(
    parameter int FREQ_W  = DEF_FREQ_W,
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int NPTS_W  = DEF_NPTS_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [FREQ_W-1:0]  f_start,
    input  logic [FREQ_W-1:0]  f_step,
    input  logic [NPTS_W-1:0]  n_points,
    input  logic [CNT_W-1:0]   settle_cycles,
    input  logic [CNT_W-1:0]   dwell_cycles,
    output logic               tone_en,
    output logic [PHASE_W-1:0] phase,
    output logic               dwell,
    output logic               pt_valid,
    input  logic               pt_ready,
    output logic [NPTS_W-1:0]  pt_idx,
    output logic [FREQ_W-1:0]  pt_freq,
    output logic               busy,
    output logic               done
);

    state_t state, state_nx;

    logic [FREQ_W-1:0] f_step_l;
    logic [NPTS_W-1:0] n_points_l;
    logic [CNT_W-1:0]  settle_l;
    logic [CNT_W-1:0]  dwell_l;
    logic [CNT_W-1:0]  cnt;

    logic load_cfg;
    logic load_first;
    logic load_next;
    logic tone_nx;
    logic settle_last;
    logic dwell_last;
    logic last_pt;
    logic acc_clr;

    // Zero-length intervals still occupy one cycle in their state.
    assign settle_last = (settle_l <= CNT_W'(1)) || (cnt == settle_l - CNT_W'(1));
    assign dwell_last  = (dwell_l  <= CNT_W'(1)) || (cnt == dwell_l  - CNT_W'(1));
    assign last_pt     = (pt_idx == n_points_l - NPTS_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        load_cfg   = 1'b0;
        load_first = 1'b0;
        load_next  = 1'b0;
        tone_en    = 1'b0;
        dwell      = 1'b0;
        pt_valid   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    load_cfg = 1'b1;
                    if (n_points == '0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx   = SETTLE;
                        load_first = 1'b1;
                    end
                end
            end
            SETTLE: begin
                tone_en = 1'b1;
                busy    = 1'b1;
                if (settle_last) state_nx = DWELL;
            end
            DWELL: begin
                tone_en = 1'b1;
                busy    = 1'b1;
                dwell   = 1'b1;
                if (dwell_last) state_nx = HANDOFF;
            end
            HANDOFF: begin
                tone_en  = 1'b1;
                busy     = 1'b1;
                pt_valid = 1'b1;
                if (pt_ready) begin
                    if (last_pt) begin
                        state_nx = DONE;
                    end else begin
                        state_nx  = SETTLE;
                        load_next = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // Abort overrides any start or handshake seen in the same cycle.
        if (abort) begin
            state_nx   = IDLE;
            load_cfg   = 1'b0;
            load_first = 1'b0;
            load_next  = 1'b0;
        end
    end

    assign tone_nx = (state_nx == SETTLE) || (state_nx == DWELL) || (state_nx == HANDOFF);
    assign acc_clr = load_first || load_next || !tone_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_step_l   <= '0;
            n_points_l <= '0;
            settle_l   <= '0;
            dwell_l    <= '0;
            cnt        <= '0;
            pt_idx     <= '0;
            pt_freq    <= '0;
        end else begin
            if (load_cfg) begin
                f_step_l   <= f_step;
                n_points_l <= n_points;
                settle_l   <= settle_cycles;
                dwell_l    <= dwell_cycles;
            end
            // The interval counter restarts on every state change.
            if ((state_nx == state) && ((state == SETTLE) || (state == DWELL))) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
            if (load_first) begin
                pt_idx  <= '0;
                pt_freq <= f_start;
            end else if (load_next) begin
                pt_idx  <= pt_idx + NPTS_W'(1);
                pt_freq <= pt_freq + f_step_l;
            end
        end
    end

    nco_phase_acc #(
        .FREQ_W  (FREQ_W),
        .PHASE_W (PHASE_W)
    ) u_nco (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (tone_en),
        .fword (pt_freq),
        .phase (phase)
    );

endmodule

// File: tb/tb_ac_sweep_stimulus.sv
// Directed-vector bench for ac_sweep_stimulus with hand-computed expectations.
module tb_ac_sweep_stimulus;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] f_start;
    logic [31:0] f_step;
    logic [9:0]  n_points;
    logic [15:0] settle_cycles;
    logic [15:0] dwell_cycles;
    logic        tone_en;
    logic [11:0] phase;
    logic        dwell;
    logic        pt_valid;
    logic        pt_ready;
    logic [9:0]  pt_idx;
    logic [31:0] pt_freq;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    ac_sweep_stimulus dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .f_start       (f_start),
        .f_step        (f_step),
        .n_points      (n_points),
        .settle_cycles (settle_cycles),
        .dwell_cycles  (dwell_cycles),
        .tone_en       (tone_en),
        .phase         (phase),
        .dwell         (dwell),
        .pt_valid      (pt_valid),
        .pt_ready      (pt_ready),
        .pt_idx        (pt_idx),
        .pt_freq       (pt_freq),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input logic [31:0] fs, input logic [31:0] fd, input logic [9:0] n,
                             input logic [15:0] st, input logic [15:0] dw);
        f_start       = fs;
        f_step        = fd;
        n_points      = n;
        settle_cycles = st;
        dwell_cycles  = dw;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pt_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_dwell(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dwell === 1'b1) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        vectors++;
        if ({tone_en, dwell, pt_valid, busy, done, phase, pt_idx, pt_freq} !== '0) begin
            miscompares++;
            $display("FAIL reset_async: outputs %h required 0",
                     {tone_en, dwell, pt_valid, busy, done, phase, pt_idx, pt_freq});
        end
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        vectors++;
        if ({tone_en, dwell, pt_valid, busy, done, phase, pt_idx, pt_freq} !== '0) begin
            miscompares++;
            $display("FAIL reset_release: outputs %h required 0",
                     {tone_en, dwell, pt_valid, busy, done, phase, pt_idx, pt_freq});
        end
    endtask

    task automatic test_sweep();
        logic [31:0] expf [3];
        int k;
        int done_cyc;
        int dwell_cnt;
        expf[0] = 32'h1000_0000;
        expf[1] = 32'h1800_0000;
        expf[2] = 32'h2000_0000;
        k = 0;
        done_cyc = 0;
        dwell_cnt = 0;
        pt_ready = 1'b1;
        configure(32'h1000_0000, 32'h0800_0000, 10'd3, 16'd4, 16'd8);
        pulse_start();
        // Scramble the configuration inputs; the latched copy must be used.
        configure(32'hDEAD_BEEF, 32'h0000_0001, 10'd7, 16'd1, 16'd1);
        for (int c = 1; c <= 80 && done_cyc == 0; c++) begin
            if (dwell === 1'b1) dwell_cnt++;
            if (pt_valid === 1'b1) begin
                vectors++;
                if (k > 2) begin
                    miscompares++;
                    $display("FAIL sweep_extra_point: pt_valid at cycle %0d after %0d points, required 3", c, k);
                end else if (pt_idx !== k[9:0] || pt_freq !== expf[k] || c != 13 * (k + 1)) begin
                    miscompares++;
                    $display("FAIL sweep_point%0d: idx %0d freq %h cycle %0d, required idx %0d freq %h cycle %0d",
                             k, pt_idx, pt_freq, c, k, expf[k], 13 * (k + 1));
                end
                k++;
            end
            if (done === 1'b1) done_cyc = c;
            if (done_cyc == 0) tick();
        end
        vectors++;
        if (k != 3) begin
            miscompares++;
            $display("FAIL sweep_point_count: got %0d required 3", k);
        end
        vectors++;
        if (done_cyc != 40) begin
            miscompares++;
            $display("FAIL sweep_done_cycle: got %0d required 40", done_cyc);
        end
        vectors++;
        if (dwell_cnt != 24) begin
            miscompares++;
            $display("FAIL sweep_dwell_cycles: got %0d required 24", dwell_cnt);
        end
    endtask

    task automatic test_phase();
        logic [11:0] ph_exp [5];
        bit ok;
        ph_exp[0] = 12'h000;
        ph_exp[1] = 12'h400;
        ph_exp[2] = 12'h800;
        ph_exp[3] = 12'hC00;
        ph_exp[4] = 12'h000;
        pt_ready = 1'b1;
        configure(32'h4000_0000, 32'h0000_0000, 10'd2, 16'd8, 16'd2);
        pulse_start();
        vectors++;
        if (phase !== 12'h000 || tone_en !== 1'b1) begin
            miscompares++;
            $display("FAIL phase_first_cycle: phase %h tone_en %b required 000 1", phase, tone_en);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (phase !== ph_exp[i]) begin
                miscompares++;
                $display("FAIL phase_step%0d: got %h required %h", i, phase, ph_exp[i]);
            end
        end
        wait_valid(ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL phase_wait_valid: timed out %b required 1", ok);
        end
        tick();
        vectors++;
        if (phase !== 12'h000 || pt_idx !== 10'd1) begin
            miscompares++;
            $display("FAIL phase_restart: phase %h idx %0d required 000 1", phase, pt_idx);
        end
        tick();
        tick();
        vectors++;
        if (phase !== 12'h400) begin
            miscompares++;
            $display("FAIL phase_restart_step: got %h required 400", phase);
        end
        wait_done(ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL phase_wait_done: timed out %b required 1", ok);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        pt_ready = 1'b0;
        configure(32'h0000_0100, 32'h0000_0200, 10'd2, 16'd1, 16'd1);
        pulse_start();
        wait_valid(ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_wait_valid: timed out %b required 1", ok);
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (pt_valid !== 1'b1 || pt_idx !== 10'd0 || pt_freq !== 32'h0000_0100 || tone_en !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold%0d: valid %b idx %0d freq %h tone %b required 1 0 00000100 1",
                         i, pt_valid, pt_idx, pt_freq, tone_en);
            end
            if (i < 4) tick();
        end
        pt_ready = 1'b1;
        tick();
        vectors++;
        if (pt_valid !== 1'b0 || pt_idx !== 10'd1 || pt_freq !== 32'h0000_0300 || dut.state !== 3'd1) begin
            miscompares++;
            $display("FAIL bp_next_point: valid %b idx %0d freq %h required 0 1 00000300 in settle",
                     pt_valid, pt_idx, pt_freq);
        end
        wait_done(ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_wait_done: timed out %b required 1", ok);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        pt_ready = 1'b1;
        configure(32'hF000_0000, 32'h2000_0000, 10'd2, 16'd2, 16'd2);
        pulse_start();
        wait_valid(ok);
        vectors++;
        if (ok !== 1'b1 || pt_freq !== 32'hF000_0000 || pt_idx !== 10'd0) begin
            miscompares++;
            $display("FAIL wrap_point0: ok %b freq %h idx %0d required 1 f0000000 0", ok, pt_freq, pt_idx);
        end
        tick();
        wait_valid(ok);
        vectors++;
        if (ok !== 1'b1 || pt_freq !== 32'h1000_0000 || pt_idx !== 10'd1) begin
            miscompares++;
            $display("FAIL wrap_point1: ok %b freq %h idx %0d required 1 10000000 1", ok, pt_freq, pt_idx);
        end
        wait_done(ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_wait_done: timed out %b required 1", ok);
        end
    endtask

    task automatic test_abort();
        bit ok;
        pt_ready = 1'b0;
        configure(32'h0100_0000, 32'h0100_0000, 10'd3, 16'd1, 16'd1);
        pulse_start();
        wait_valid(ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_wait_valid: timed out %b required 1", ok);
        end
        abort    = 1'b1;
        pt_ready = 1'b1;
        start    = 1'b1;
        tick();
        abort    = 1'b0;
        start    = 1'b0;
        vectors++;
        if ({pt_valid, tone_en, done, busy, dwell} !== 5'b0 || phase !== 12'h000) begin
            miscompares++;
            $display("FAIL abort_idle: valid/tone/done/busy/dwell %b phase %h required 00000 000",
                     {pt_valid, tone_en, done, busy, dwell}, phase);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || pt_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_stays_idle: busy %b valid %b required 0 0", busy, pt_valid);
        end
    endtask

    task automatic test_zero_points();
        pt_ready = 1'b1;
        configure(32'h1234_5678, 32'h0000_0001, 10'd0, 16'd3, 16'd3);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_pts_pre: done %b required 0", done);
        end
        pulse_start();
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || pt_valid !== 1'b0 || tone_en !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_pts_done: done %b busy %b valid %b tone %b required 1 0 0 0",
                     done, busy, pt_valid, tone_en);
        end
    endtask

    task automatic test_zero_intervals();
        int dwell_cnt;
        int valid_cnt;
        int done_cyc;
        dwell_cnt = 0;
        valid_cnt = 0;
        done_cyc  = 0;
        pt_ready  = 1'b1;
        configure(32'h0000_1000, 32'h0000_1000, 10'd2, 16'd0, 16'd0);
        pulse_start();
        for (int c = 1; c <= 30 && done_cyc == 0; c++) begin
            if (dwell === 1'b1) dwell_cnt++;
            if (pt_valid === 1'b1) valid_cnt++;
            if (done === 1'b1) done_cyc = c;
            if (done_cyc == 0) tick();
        end
        vectors++;
        if (dwell_cnt != 2 || valid_cnt != 2) begin
            miscompares++;
            $display("FAIL zero_len_counts: dwell %0d valid %0d required 2 2", dwell_cnt, valid_cnt);
        end
        vectors++;
        if (done_cyc != 7) begin
            miscompares++;
            $display("FAIL zero_len_done_cycle: got %0d required 7", done_cyc);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        pt_ready = 1'b1;
        configure(32'h0800_0000, 32'h0100_0000, 10'd2, 16'd2, 16'd8);
        pulse_start();
        wait_dwell(ok);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_wait_dwell: timed out %b required 1", ok);
        end
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({tone_en, dwell, pt_valid, busy, done, phase, pt_idx, pt_freq} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_async: outputs %h required 0",
                     {tone_en, dwell, pt_valid, busy, done, phase, pt_idx, pt_freq});
        end
        #3 rst_n = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0 || pt_valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_after: busy %b valid %b done %b required 0 0 0", busy, pt_valid, done);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        pt_ready    = 1'b0;
        configure(32'h0, 32'h0, 10'd0, 16'd0, 16'd0);

        test_reset();
        test_sweep();
        test_phase();
        test_backpressure();
        test_wrap();
        test_abort();
        test_zero_points();
        test_zero_intervals();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
